// File: rtl/masking_share_encoder_3sh.sv
// masking_share_encoder_3sh: producer end of the 3-share masked LED datapath.
//
// Takes an unshared WIDTH-bit word over a valid/ready handshake, gathers 2*WIDTH
// fresh bits from an internal seeded 32-bit Galois LFSR over NCYC = 2*WIDTH/RPC
// cycles, and presents a Boolean 3-share encoding (sh1 ^ sh2 ^ sh3 = data) on a
// second valid/ready handshake. All share outputs come straight from registers.
//
// Build option: define ENC_ZERO_RAND_EN to force the random buffer to zero
// (sh1 = sh2 = 0, sh3 = data) for functional debug. Timing, handshakes and
// LFSR stepping are identical to the masked build.

module masking_share_encoder_3sh #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned RPC   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  input  logic [31:0]      seed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sh1,
  output logic [WIDTH-1:0] out_sh2,
  output logic [WIDTH-1:0] out_sh3,
  output logic             busy
);

  // Random buffer width and number of GEN cycles needed to fill it.
  localparam int unsigned RandW = 2 * WIDTH;
  localparam int unsigned NCYC  = RandW / RPC;
  localparam int unsigned CntW  = (NCYC > 1) ? $clog2(NCYC) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(NCYC - 1);

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form.
  localparam logic [31:0] LfsrTaps  = 32'h8020_0003;
  localparam logic [31:0] LfsrReset = 32'h0000_0001;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StGen  = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [RandW-1:0] rand_q, rand_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [WIDTH-1:0] sh2_q, sh2_d;
  logic [WIDTH-1:0] sh3_q, sh3_d;

  logic [31:0]      lfsr_next;
  logic [RandW-1:0] rand_fill;
  logic             accept;
  logic             gen_last;

  // Unrolled RPC single steps of the LFSR, used only while in GEN.
  always_comb begin
    lfsr_next = lfsr_q;
    for (int i = 0; i < int'(RPC); i++) begin
      if (lfsr_next[0]) begin
        lfsr_next = (lfsr_next >> 1) ^ LfsrTaps;
      end else begin
        lfsr_next = lfsr_next >> 1;
      end
    end
  end

  // Buffer contents after this GEN cycle: shift left, new bits at the LSBs.
`ifdef ENC_ZERO_RAND_EN
  assign rand_fill = '0;
`else
  assign rand_fill = {rand_q[RandW-RPC-1:0], lfsr_next[RPC-1:0]};
`endif

  // Handshake-side decodes.
  assign in_ready  = (state_q == StIdle) && !seed_valid;
  assign accept    = in_valid && in_ready;
  assign gen_last  = (cnt_q == CntLast);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign out_sh1   = sh1_q;
  assign out_sh2   = sh2_q;
  assign out_sh3   = sh3_q;

  // Next-state logic for the FSM, LFSR, buffers and share registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    rand_d  = rand_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    sh3_d   = sh3_q;

    unique case (state_q)
      StIdle: begin
        if (seed_valid) begin
          // An all-zero seed would lock the LFSR; fall back to the reset value.
          lfsr_d = (seed == 32'h0) ? LfsrReset : seed;
        end else if (accept) begin
          data_d  = in_data;
          cnt_d   = '0;
          state_d = StGen;
        end
      end

      StGen: begin
        lfsr_d = lfsr_next;
        rand_d = rand_fill;
        cnt_d  = cnt_q + 1'b1;
        if (gen_last) begin
          // sh3 is formed only at the register input, so the unmasked word
          // never reaches an output through combinational logic.
          sh1_d   = rand_fill[WIDTH-1:0];
          sh2_d   = rand_fill[RandW-1:WIDTH];
          sh3_d   = data_q ^ rand_fill[WIDTH-1:0] ^ rand_fill[RandW-1:WIDTH];
          cnt_d   = '0;
          state_d = StOut;
        end
      end

      StOut: begin
        if (out_ready) begin
          // Scrub the word and its randomness once the consumer has them.
          data_d  = '0;
          rand_d  = '0;
          sh1_d   = '0;
          sh2_d   = '0;
          sh3_d   = '0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lfsr_q  <= LfsrReset;
      data_q  <= '0;
      rand_q  <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      sh3_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      rand_q  <= rand_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      sh3_q   <= sh3_d;
    end
  end

endmodule

// File: tb/tb_masking_share_encoder_3sh.sv
// Directed self-checking bench for masking_share_encoder_3sh at default
// parameters. Expected shares come from a bit-serial reference LFSR model.
// Define ENC_ZERO_RAND_EN for both bench and RTL to check the debug mode.

module tb_masking_share_encoder_3sh;

  localparam int W    = 64;
  localparam int RPC  = 16;
  localparam int NCYC = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          seed_valid;
  logic [31:0]   seed;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sh1;
  logic [W-1:0]  out_sh2;
  logic [W-1:0]  out_sh3;
  logic          busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_lfsr;

  always #5 clk = ~clk;

  masking_share_encoder_3sh #(
    .WIDTH (W),
    .RPC   (RPC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_valid (seed_valid),
    .seed       (seed),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sh1    (out_sh1),
    .out_sh2    (out_sh2),
    .out_sh3    (out_sh3),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One Galois step: take the LSB, shift right, apply taps if it was set.
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic fb;
    fb = s[0];
    s  = {1'b0, s[31:1]};
    if (fb) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  // Reference shares for one word; advances model_lfsr by NCYC*RPC steps.
  task automatic model_word(input logic [W-1:0] d, output logic [W-1:0] e1,
                            output logic [W-1:0] e2, output logic [W-1:0] e3);
    logic [2*W-1:0] r;
    r = '0;
    for (int c = 0; c < NCYC; c++) begin
      for (int k = 0; k < RPC; k++) model_lfsr = ref_step(model_lfsr);
      r = {r[2*W-RPC-1:0], model_lfsr[RPC-1:0]};
    end
`ifdef ENC_ZERO_RAND_EN
    r = '0;
`endif
    e1 = r[W-1:0];
    e2 = r[2*W-1:W];
    e3 = d ^ e1 ^ e2;
  endtask

  // Present a word in IDLE, wait (bounded) for out_valid; lat counts cycles
  // from the accept cycle to the first out_valid cycle.
  task automatic send_word(input logic [W-1:0] d, output logic [W-1:0] s1,
                           output logic [W-1:0] s2, output logic [W-1:0] s3,
                           output int lat);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    s1 = out_sh1;
    s2 = out_sh2;
    s3 = out_sh3;
  endtask

  // Full word check against the model, then one-cycle out_ready release.
  task automatic word_and_check(input string tag, input logic [W-1:0] d,
                                output logic [W-1:0] got1);
    logic [W-1:0] s1, s2, s3, e1, e2, e3;
    int lat;
    model_word(d, e1, e2, e3);
    send_word(d, s1, s2, s3, lat);
    chk({tag, "_latency"}, 64'(lat), 64'd9);
    chk({tag, "_recombine"}, s1 ^ s2 ^ s3, d);
    chk({tag, "_sh1"}, s1, e1);
    chk({tag, "_sh2"}, s2, e2);
    got1 = s1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] a1, a2, a3, e1, e2, e3, w1, w2, dummy;
    int lat;
    int bad;

    rst        = 1'b1;
    seed_valid = 1'b0;
    seed       = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state.
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sh1", out_sh1, 64'd0);
    chk("rst_sh2", out_sh2, 64'd0);
    chk("rst_sh3", out_sh3, 64'd0);

    // Seed load; in_ready drops combinationally while seed_valid is high.
    seed_valid = 1'b1;
    seed       = 32'hACE1_2345;
    #1;
    chk("seed_blocks_in_ready", 64'(in_ready), 64'd0);
    tick();
    seed_valid = 1'b0;
    model_lfsr = 32'hACE1_2345;

    // First word, with a busy check in GEN.
    model_word(64'h0123_4567_89AB_CDEF, e1, e2, e3);
    in_data  = 64'h0123_4567_89AB_CDEF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("gen_busy", 64'(busy), 64'd1);
    chk("gen_in_ready", 64'(in_ready), 64'd0);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk("w0_latency", 64'(lat), 64'd9);
    chk("w0_recombine", out_sh1 ^ out_sh2 ^ out_sh3, 64'h0123_4567_89AB_CDEF);
    chk("w0_sh1", out_sh1, e1);
    chk("w0_sh2", out_sh2, e2);
    chk("w0_sh3", out_sh3, e3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("w0_out_valid_drop", 64'(out_valid), 64'd0);
    chk("w0_in_ready_back", 64'(in_ready), 64'd1);

    // Two identical words back to back must use different randomness.
    word_and_check("ff1", 64'hFFFF_FFFF_FFFF_FFFF, w1);
    word_and_check("ff2", 64'hFFFF_FFFF_FFFF_FFFF, w2);
`ifndef ENC_ZERO_RAND_EN
    chk("ff_sh1_fresh", 64'(w1 != w2), 64'd1);
`endif

    // Backpressure: 20 cycles of held OUT with in_valid/seed_valid toggling.
    model_word(64'h5A5A_0F0F_3C3C_9696, e1, e2, e3);
    send_word(64'h5A5A_0F0F_3C3C_9696, a1, a2, a3, lat);
    chk("bp_latency", 64'(lat), 64'd9);
    chk("bp_sh1", a1, e1);
    chk("bp_sh3", a3, e3);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid   = i[0];
      seed_valid = ~i[0];
      seed       = 32'h1234_5678;
      in_data    = 64'hAAAA_5555_AAAA_5555;
      tick();
      if (out_sh1 !== a1 || out_sh2 !== a2 || out_sh3 !== a3) bad++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    chk("bp_held_stable", 64'(bad), 64'd0);
    in_valid   = 1'b0;
    seed_valid = 1'b0;
    out_ready  = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    tick();
    chk("bp_no_second_accept", 64'(busy), 64'd0);
    // LFSR held and seed ignored during backpressure: next word follows model.
    word_and_check("post_bp", 64'h0000_0000_0000_0001, dummy);

    // Seed 0 together with in_valid: seed wins, word taken next cycle.
    seed_valid = 1'b1;
    seed       = 32'h0;
    in_valid   = 1'b1;
    in_data    = 64'hCAFE_F00D_1234_8765;
    tick();
    seed_valid = 1'b0;
    chk("seed_wins_not_accepted", 64'(busy), 64'd0);
    model_lfsr = 32'h1;
    word_and_check("seed0", 64'hCAFE_F00D_1234_8765, dummy);

    // Reset in the middle of GEN discards the word.
    seed_valid = 1'b1;
    seed       = 32'h1357_9BDF;
    tick();
    seed_valid = 1'b0;
    in_data    = 64'h1111_2222_3333_4444;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_sh3", out_sh3, 64'd0);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid !== 1'b0) bad++;
      tick();
    end
    chk("midrst_no_out_valid", 64'(bad), 64'd0);
    // LFSR reverted to 32'h1 by the reset.
    model_lfsr = 32'h1;
    word_and_check("post_rst", 64'h8765_4321_0FED_CBA9, dummy);

    // Debug-mode vector; in the masked build this is a plain model check.
    model_word(64'hDEAD_BEEF_0000_1111, e1, e2, e3);
    send_word(64'hDEAD_BEEF_0000_1111, a1, a2, a3, lat);
    chk("dbg_latency", 64'(lat), 64'd9);
    chk("dbg_sh1", a1, e1);
    chk("dbg_sh2", a2, e2);
    chk("dbg_sh3", a3, e3);
`ifdef ENC_ZERO_RAND_EN
    chk("dbg_sh3_is_data", a3, 64'hDEAD_BEEF_0000_1111);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
